// File: rtl/chs_scheduler.sv
// Temperature-loop sequencer producing the CoolHeatSystem configuration byte:
// heat/cool decision, rate-limited power ramp, drain and dead time on reversal.
module chs_scheduler #(
  parameter int DEAD_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int HYST        = 2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       enable,
  input  logic [7:0] temp,
  input  logic [7:0] setpoint,
  output logic [7:0] chs_conf,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam int PWR_W  = 4;
  localparam int SW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DW     = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic signed [DATA_W:0] HYST_S   = (DATA_W+1)'(HYST);
  localparam logic signed [DATA_W:0] PWR_MAX  = (DATA_W+1)'(15);
  localparam logic [SW-1:0]          STEP_END = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0]          DEAD_END = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RAMP, DRAIN, DEAD} state_t;
  typedef enum logic [1:0] {DEM_NONE, DEM_HEAT, DEM_COOL} demand_t;

  state_t      state, state_nxt;
  logic        mode, mode_nxt;
  logic [PWR_W-1:0] power, power_nxt;
  logic [SW-1:0]    step_cnt, step_cnt_nxt;
  logic [DW-1:0]    dead_cnt, dead_cnt_nxt;
  logic [7:0]       conf_nxt;

  logic signed [DATA_W:0] err;
  demand_t          demand;
  logic             dem_opp, dem_same, dem_mode;
  logic             tick, active_nxt, keep_cnt;
  logic [PWR_W-1:0] target;

  // Magnitude of the error clamped to the 4-bit power range.
  function automatic logic [PWR_W-1:0] sat_power(input logic signed [DATA_W:0] e);
    logic signed [DATA_W:0] mag;
    mag = (e < 0) ? -e : e;
    if (mag > PWR_MAX) return {PWR_W{1'b1}};
    return mag[PWR_W-1:0];
  endfunction

  function automatic logic [PWR_W-1:0] step_toward(input logic [PWR_W-1:0] p,
                                                   input logic [PWR_W-1:0] tgt);
    if (p < tgt) return p + PWR_W'(1);
    if (p > tgt) return p - PWR_W'(1);
    return p;
  endfunction

  // Stage 0: 9-bit signed error and demand classification.
  assign err = $signed({1'b0, temp}) - $signed({1'b0, setpoint});

  always_comb begin
    demand = DEM_NONE;
    if (enable) begin
      if (err > HYST_S)       demand = DEM_COOL;
      else if (err < -HYST_S) demand = DEM_HEAT;
    end
  end

  assign dem_mode = (demand == DEM_COOL);
  assign dem_opp  = (demand == DEM_COOL && !mode) || (demand == DEM_HEAT && mode);
  assign dem_same = (demand == DEM_COOL && mode) || (demand == DEM_HEAT && !mode);

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    case (state)
      IDLE: begin
        if (demand != DEM_NONE) begin
          state_nxt = RAMP;
          mode_nxt  = dem_mode;
        end
      end
      RAMP: begin
        if (dem_opp)                                      state_nxt = DRAIN;
        else if (demand == DEM_NONE && power == '0)       state_nxt = IDLE;
      end
      DRAIN: begin
        if (dem_same)           state_nxt = RAMP;
        else if (power == '0)   state_nxt = dem_opp ? DEAD : IDLE;
      end
      DEAD: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (dead_cnt == DEAD_END) begin
          if (demand != DEM_NONE) begin
            state_nxt = RAMP;
            mode_nxt  = dem_mode;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Step timing: a tick on a transition edge steps toward the new state's target;
  // DRAIN->RAMP keeps the running count so the ramp cadence is unbroken.
  always_comb begin
    tick       = (state == RAMP || state == DRAIN) && (step_cnt == STEP_END);
    active_nxt = (state_nxt == RAMP) || (state_nxt == DRAIN);
    keep_cnt   = (state == RAMP && state_nxt == RAMP) ||
                 (state == DRAIN && active_nxt);

    step_cnt_nxt = '0;
    if (active_nxt && keep_cnt && !tick) step_cnt_nxt = step_cnt + SW'(1);

    dead_cnt_nxt = '0;
    if (state == DEAD && state_nxt == DEAD) dead_cnt_nxt = dead_cnt + DW'(1);

    target = '0;
    if (state_nxt == RAMP && demand != DEM_NONE) target = sat_power(err);

    power_nxt = '0;
    if (active_nxt) power_nxt = tick ? step_toward(power, target) : power;

    case (state_nxt)
      RAMP, DRAIN: conf_nxt = {1'b1, mode_nxt, 2'b00, power_nxt};
      DEAD:        conf_nxt = {1'b0, mode_nxt, 2'b00, 4'h0};
      default:     conf_nxt = 8'h00;
    endcase
  end

  // Stage 1: state and configuration register.
  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= IDLE;
      mode     <= 1'b0;
      power    <= '0;
      step_cnt <= '0;
      dead_cnt <= '0;
      chs_conf <= 8'h00;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      power    <= power_nxt;
      step_cnt <= step_cnt_nxt;
      dead_cnt <= dead_cnt_nxt;
      chs_conf <= conf_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_chs_scheduler.sv
// Scoreboard bench for chs_scheduler: per-cycle expected chs_conf/busy queued
// from the timing rules, compared 1 time unit after each rising edge.
module tb_chs_scheduler;

  localparam int STEP = 8;

  logic       clk = 1'b0;
  logic       arst;
  logic       enable;
  logic [7:0] temp;
  logic [7:0] setpoint;
  logic [7:0] chs_conf;
  logic       busy;

  typedef struct packed {
    logic [7:0] conf;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  chs_scheduler #(.DEAD_CYCLES(16), .STEP_CYCLES(STEP), .HYST(2)) dut (
    .clk      (clk),
    .arst     (arst),
    .enable   (enable),
    .temp     (temp),
    .setpoint (setpoint),
    .chs_conf (chs_conf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog chs_conf=%h busy=%b required=finish", chs_conf, busy);
    $fatal(1);
  end

  task automatic push_run(input logic [7:0] conf, input logic b, input int n);
    exp_t e;
    e.conf = conf;
    e.busy = b;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // STEP cycles at each power level from p_from to p_to inclusive.
  task automatic push_ramp(input logic [7:0] hi, input int p_from, input int p_to);
    int p;
    p = p_from;
    while (1) begin
      push_run(hi | 8'(p), 1'b1, STEP);
      if (p == p_to) break;
      p = (p_to > p_from) ? p + 1 : p - 1;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    exp_t e;
    arst = 1'b1; enable = 1'b0; temp = 8'd0; setpoint = 8'd0;
    push_run(8'h00, 1'b0, 1);
    push_ramp(8'hC0, 0, 4);
    push_run(8'hC5, 1'b1, 1);
    push_run(8'h00, 1'b0, 2);
    push_run(8'hC0, 1'b1, STEP);
    push_run(8'hC1, 1'b1, 1);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 1)  begin arst = 1'b0; setpoint = 8'd100; temp = 8'd110; enable = 1'b1; end
      if (c == 42) arst = 1'b1;
      if (c == 44) arst = 1'b0;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL reset cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  task automatic test_cool_ramp();
    int c;
    exp_t e;
    do_reset();
    setpoint = 8'd100; temp = 8'd110; enable = 1'b1;
    push_ramp(8'hC0, 0, 9);
    push_run(8'hCA, 1'b1, 17);
    c = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL cool_ramp cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  // Continues from the held 0xCA left by test_cool_ramp.
  task automatic test_reversal();
    int c;
    exp_t e;
    temp = 8'd90;
    push_ramp(8'hC0, 10, 1);
    push_run(8'hC0, 1'b1, 1);
    push_run(8'h40, 1'b1, 16);
    push_ramp(8'h80, 0, 9);
    push_run(8'h8A, 1'b1, 4);
    c = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL reversal cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  task automatic test_band();
    int c;
    exp_t e;
    do_reset();
    setpoint = 8'd100; temp = 8'd102; enable = 1'b1;
    push_run(8'h00, 1'b0, 8);
    push_run(8'hC0, 1'b1, 2);
    push_run(8'h00, 1'b0, 1);
    push_run(8'h80, 1'b1, 2);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 4)  temp = 8'd98;
      if (c == 8)  temp = 8'd103;
      if (c == 10) arst = 1'b1;
      if (c == 11) begin arst = 1'b0; setpoint = 8'd250; temp = 8'd5; end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL band cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  task automatic test_saturation_abort();
    int c;
    exp_t e;
    do_reset();
    setpoint = 8'd20; temp = 8'd200; enable = 1'b1;
    push_ramp(8'hC0, 0, 14);
    push_run(8'hCF, 1'b1, 1);
    push_run(8'hCF, 1'b1, 7);
    push_ramp(8'hC0, 14, 1);
    push_run(8'hC0, 1'b1, 1);
    push_run(8'h00, 1'b0, 3);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 121) enable = 1'b0;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL saturation_abort cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  task automatic test_drain_return();
    int c;
    exp_t e;
    do_reset();
    setpoint = 8'd100; temp = 8'd110; enable = 1'b1;
    push_ramp(8'hC0, 0, 9);
    push_run(8'hCA, 1'b1, 17);
    push_ramp(8'hC0, 10, 7);
    push_run(8'hC6, 1'b1, 1);
    push_run(8'hC6, 1'b1, 7);
    push_ramp(8'hC0, 7, 9);
    push_run(8'hCA, 1'b1, 10);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 97)  temp = 8'd90;
      if (c == 130) temp = 8'd110;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL drain_return cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  // Reversal sampled on the same edge as a step tick: the tick already drains.
  task automatic test_tick_on_reversal();
    int c;
    exp_t e;
    do_reset();
    setpoint = 8'd100; temp = 8'd110; enable = 1'b1;
    push_ramp(8'hC0, 0, 9);
    push_run(8'hCA, 1'b1, 24);
    push_ramp(8'hC0, 9, 1);
    push_run(8'hC0, 1'b1, 1);
    push_run(8'h40, 1'b1, 16);
    push_run(8'h80, 1'b1, 2);
    c = 0;
    while (sb.size() > 0) begin
      if (c == 104) temp = 8'd90;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (chs_conf !== e.conf || busy !== e.busy) begin
        failures++;
        $display("FAIL tick_on_reversal cyc=%0d chs_conf=%h busy=%b expected=%h/%b",
                 c, chs_conf, busy, e.conf, e.busy);
      end
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_cool_ramp();
    test_reversal();
    test_band();
    test_saturation_abort();
    test_drain_return();
    test_tick_on_reversal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chs_scheduler.md
# chs_scheduler

Closed-loop sequencer that generates the `chs_conf` configuration byte for CoolHeatSystem from a measured temperature and a setpoint. It decides heat/cool mode and a 4-bit power level, ramps power one step at a time, and enforces a drain-to-zero plus dead-time interval before any heat/cool reversal. It sits directly upstream of CoolHeatSystem and drives its `chs_conf` input on the same clock.

## Interface
Parameters:
- `DEAD_CYCLES`, 16: cycles held at zero power with output disabled between a drain and a mode reversal (≥1).
- `STEP_CYCLES`, 8: cycles between successive ±1 power steps (≥1).
- `HYST`, 2: half-width of the no-demand band around the setpoint, in temperature LSBs (0..15).

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `arst`, in, 1: reset, **synchronous, active-high**.
- `enable`, in, 1: master enable; low forces a drain to idle.
- `temp`, in, 8: measured temperature, unsigned.
- `setpoint`, in, 8: target temperature, unsigned.
- `chs_conf`, out, 8: registered configuration to CoolHeatSystem.
  - [7] = output enable.
  - [6] = mode (1 cool, 0 heat).
  - [5:4] = 0.
  - [3:0] = power.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Error `e = temp - setpoint`, 9-bit signed; there is no 8-bit wrap.
- Demand:
  - COOL if `e > HYST`.
  - HEAT if `e < -HYST`.
  - NONE otherwise; `|e| == HYST` is inside the band.
  - NONE is also forced when `enable` = 0.
- Target power = `min(|e|, 15)` for COOL/HEAT; 0 for NONE.
- State register `mode` holds the current mode; it resets to 0 (heat).
- IDLE (power 0, [7] = 0):
  - On COOL/HEAT: load `mode` from the demand directly (no dead time), go to RAMP.
- RAMP ([7] = 1):
  - Power moves ±1 toward target on each step tick; it never overshoots.
  - Demand opposite to `mode` → DRAIN.
  - NONE and power == 0 → IDLE.
- DRAIN ([7] = 1): target is forced to 0; power −1 per step tick.
  - Demand returns to the same mode as `mode` → RAMP, keeping the current power.
  - Power == 0 → DEAD if the demand is opposite, else IDLE.
- DEAD ([7] = 0, power 0, `mode` unchanged): counts DEAD_CYCLES cycles.
  - At the end of the count: COOL/HEAT → load `mode` from the demand, go to RAMP; NONE → IDLE.
  - `enable` = 0 during DEAD → IDLE on the next edge.
- Step tick: a counter 0..STEP_CYCLES-1.
  - It clears on entry to RAMP or DRAIN.
  - It ticks when count == STEP_CYCLES-1, then wraps to 0.
- Power is held in [3:0] at all times. It is 0 in IDLE and DEAD.

## Timing
- Reset values on the edge with `arst` = 1:
  - `chs_conf` = 0x00, `busy` = 0.
  - State IDLE, `mode` = 0.
  - Step counter 0, dead counter 0.
- Reset takes priority over every other event. Reset asserted mid-RAMP/DRAIN/DEAD aborts to these values on that edge.
- Inputs are sampled each edge. The state and `chs_conf` update on the same edge, so there is 1 cycle of latency from an input change to the output.
- IDLE → RAMP: `chs_conf` = {1, mode, 00, 0000} on the first edge. The first power increment comes STEP_CYCLES edges later.
- Full reversal from power P: P·STEP_CYCLES cycles of DRAIN, then DEAD_CYCLES cycles of DEAD, then RAMP with the new mode at power 0.
- A demand change and a step tick on the same edge: the tick uses the new state's target. A DRAIN→RAMP transition keeps the counter running; it does not re-clear it.

## Test plan
- Reset: `arst` = 1 for 2 edges mid-ramp (power 5) → `chs_conf` = 0x00, `busy` = 0 on the first reset edge. No change between edges.
- Cool ramp: setpoint 100, temp 110, enable 1.
  - → `chs_conf` = 0xC0 one edge later.
  - → 0xC1 after a further 8 cycles.
  - → 0xCA after 80 cycles, then held.
- Band: setpoint 100, temp 102 and temp 98 → `chs_conf` stays 0x00, `busy` = 0. At temp 103 → RAMP cool.
- Reversal: from 0xCA, temp → 90.
  - → Power steps down to 0xC0 over 80 cycles.
  - → 0x40 for 16 cycles.
  - → 0x80, then rises to 0x8A over 80 cycles.
- Saturation and abort:
  - setpoint 20, temp 200 → settles at 0xCF.
  - Then `enable` = 0 → drains to 0xC0 over 120 cycles → 0x00, `busy` = 0.
- Return during drain: reversal begun at 0xCA, temp back to 110 when power = 6 → RAMP, climbs to 0xCA. DEAD is never entered.
